// File: rtl/pipeline_mem_stage_hs_if.sv
// EX -> MEM -> WB handshake bundle plus the data-memory request/ack bus; master = MEM stage, slave = its surroundings.
// misalign_MEM exists only when MEM_MISALIGN_CHECK_EN is defined.
interface pipeline_mem_stage_hs_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   alu_result_EX;
    logic [XLEN-1:0]   reg_data2_EX;
    logic [REG_AW-1:0] rd_EX;
    logic [XLEN-1:0]   pc_EX;
    logic [2:0]        dm_rd_ctrl_EX;
    logic [2:0]        dm_wr_ctrl_EX;
    logic              rf_wr_en_EX;
    logic [SEL_W-1:0]  rf_wr_sel_EX;

    logic              dm_req;
    logic [XLEN-1:0]   dm_addr;
    logic [XLEN-1:0]   dm_din;
    logic [2:0]        dm_rd_ctrl;
    logic [2:0]        dm_wr_ctrl;
    logic              dm_ack;
    logic [XLEN-1:0]   dm_dout;
    logic              memorying;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   pc_WB;
    logic [SEL_W-1:0]  rf_wr_sel_MEM;
    logic              rf_wr_en_MEM;
    logic [XLEN-1:0]   mem_data_MEM;
    logic [XLEN-1:0]   alu_result_MEM;
    logic [REG_AW-1:0] rd_MEM;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              misalign_MEM;
`endif

    modport master (
        input  in_valid, alu_result_EX, reg_data2_EX, rd_EX, pc_EX,
               dm_rd_ctrl_EX, dm_wr_ctrl_EX, rf_wr_en_EX, rf_wr_sel_EX,
               dm_ack, dm_dout, out_ready,
        output in_ready, dm_req, dm_addr, dm_din, dm_rd_ctrl, dm_wr_ctrl, memorying,
               out_valid, pc_WB, rf_wr_sel_MEM, rf_wr_en_MEM, mem_data_MEM,
               alu_result_MEM, rd_MEM
`ifdef MEM_MISALIGN_CHECK_EN
        , output misalign_MEM
`endif
    );

    modport slave (
        output in_valid, alu_result_EX, reg_data2_EX, rd_EX, pc_EX,
               dm_rd_ctrl_EX, dm_wr_ctrl_EX, rf_wr_en_EX, rf_wr_sel_EX,
               dm_ack, dm_dout, out_ready,
        input  in_ready, dm_req, dm_addr, dm_din, dm_rd_ctrl, dm_wr_ctrl, memorying,
               out_valid, pc_WB, rf_wr_sel_MEM, rf_wr_en_MEM, mem_data_MEM,
               alu_result_MEM, rd_MEM
`ifdef MEM_MISALIGN_CHECK_EN
        , input misalign_MEM
`endif
    );
endinterface

// File: rtl/pipeline_mem_stage_hs.sv
// Handshaked MEM stage: latency 1 cycle (non-memory) or dm_ack+1; WB backpressure holds the result and stalls EX.
// Optional MEM_MISALIGN_CHECK_EN flags misaligned accesses and completes them without touching memory.
module pipeline_mem_stage_hs #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input logic                    clk,
    input logic                    reset,
    pipeline_mem_stage_hs_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]        state;
    logic [XLEN-1:0]   addr_q, din_q, pc_q, mem_data_q;
    logic [2:0]        rd_ctrl_q, wr_ctrl_q;
    logic [REG_AW-1:0] rd_q;
    logic [SEL_W-1:0]  sel_q;
    logic              wr_en_q, req_q, valid_q;

    logic              accept, is_load, is_store, misalign;
    logic [XLEN-1:0]   load_ext;

    assign bus.in_ready = !reset && ((state == IDLE) || (state == HOLD && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_load      = (bus.dm_rd_ctrl_EX != 3'd0);
    assign is_store     = (bus.dm_wr_ctrl_EX >= 3'd1) && (bus.dm_wr_ctrl_EX <= 3'd4);

`ifdef MEM_MISALIGN_CHECK_EN
    logic [1:0] size;
    logic       misalign_q;

    always_comb begin
        size = 2'd0;
        if (is_load) begin
            case (bus.dm_rd_ctrl_EX)
                3'd3, 3'd4: size = 2'd1;
                3'd5, 3'd6: size = 2'd2;
                3'd7:       size = (XLEN == 64) ? 2'd3 : 2'd2;
                default:    size = 2'd0;
            endcase
        end else if (is_store) begin
            size = bus.dm_wr_ctrl_EX[1:0] - 2'd1;
        end
    end

    always_comb begin
        case (size)
            2'd1:    misalign = bus.alu_result_EX[0];
            2'd2:    misalign = |bus.alu_result_EX[1:0];
            2'd3:    misalign = |bus.alu_result_EX[2:0];
            default: misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       misalign_q <= 1'b0;
        else if (accept) misalign_q <= misalign;
    end
    assign bus.misalign_MEM = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Memory returns data LSB-aligned; widen according to the registered load type.
    always_comb begin
        case (rd_ctrl_q)
            3'd1:    load_ext = XLEN'($signed(bus.dm_dout[7:0]));
            3'd2:    load_ext = XLEN'(bus.dm_dout[7:0]);
            3'd3:    load_ext = XLEN'($signed(bus.dm_dout[15:0]));
            3'd4:    load_ext = XLEN'(bus.dm_dout[15:0]);
            3'd5:    load_ext = XLEN'($signed(bus.dm_dout[31:0]));
            3'd6:    load_ext = (XLEN == 64) ? XLEN'(bus.dm_dout[31:0])
                                             : XLEN'($signed(bus.dm_dout[31:0]));
            3'd7:    load_ext = bus.dm_dout;
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            pc_q       <= '0;
            mem_data_q <= '0;
            rd_ctrl_q  <= 3'd0;
            wr_ctrl_q  <= 3'd0;
            rd_q       <= '0;
            sel_q      <= '0;
            wr_en_q    <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state)
                ACCESS: if (bus.dm_ack) begin
                    mem_data_q <= load_ext;
                    req_q      <= 1'b0;
                    valid_q    <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: if (bus.out_ready && !accept) begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: ;
            endcase

            if (accept) begin
                addr_q     <= bus.alu_result_EX;
                din_q      <= bus.reg_data2_EX;
                pc_q       <= bus.pc_EX;
                rd_q       <= bus.rd_EX;
                sel_q      <= bus.rf_wr_sel_EX;
                rd_ctrl_q  <= bus.dm_rd_ctrl_EX;
                // A load wins over a simultaneous store; out-of-range store codes are no-ops.
                wr_ctrl_q  <= (!is_load && is_store) ? bus.dm_wr_ctrl_EX : 3'd0;
                wr_en_q    <= bus.rf_wr_en_EX && !misalign;
                mem_data_q <= '0;
                if ((is_load || is_store) && !misalign) begin
                    state   <= ACCESS;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end else begin
                    state   <= HOLD;
                    req_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.dm_req         = req_q;
    assign bus.dm_addr        = addr_q;
    assign bus.dm_din         = din_q;
    assign bus.dm_rd_ctrl     = rd_ctrl_q;
    assign bus.dm_wr_ctrl     = wr_ctrl_q;
    assign bus.memorying      = (state == ACCESS);
    assign bus.out_valid      = valid_q;
    assign bus.pc_WB          = pc_q;
    assign bus.rf_wr_sel_MEM  = sel_q;
    assign bus.rf_wr_en_MEM   = wr_en_q;
    assign bus.mem_data_MEM   = mem_data_q;
    assign bus.alu_result_MEM = addr_q;
    assign bus.rd_MEM         = rd_q;
endmodule

// File: tb/tb_pipeline_mem_stage_hs.sv
// Directed bench for pipeline_mem_stage_hs (XLEN=64); inputs change 1 time unit after each rising edge.
module tb_pipeline_mem_stage_hs;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_mem_stage_hs_if #(.XLEN(64), .REG_AW(5), .SEL_W(2)) bus_if ();

    pipeline_mem_stage_hs #(.XLEN(64), .REG_AW(5), .SEL_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus_if.in_valid      = 1'b0;
        bus_if.alu_result_EX = '0;
        bus_if.reg_data2_EX  = '0;
        bus_if.rd_EX         = '0;
        bus_if.pc_EX         = '0;
        bus_if.dm_rd_ctrl_EX = 3'd0;
        bus_if.dm_wr_ctrl_EX = 3'd0;
        bus_if.rf_wr_en_EX   = 1'b0;
        bus_if.rf_wr_sel_EX  = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        bus_if.out_ready = 1'b0;
        bus_if.dm_ack    = 1'b0;
        bus_if.dm_dout   = '0;
        tick();
        tick();
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_dm_req", bus_if.dm_req, 0);
        chk("rst_in_ready", bus_if.in_ready, 0);
        chk("rst_mem_data", bus_if.mem_data_MEM, 0);
        chk("rst_rd_mem", bus_if.rd_MEM, 0);
        chk("rst_memorying", bus_if.memorying, 0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", bus_if.in_ready, 1);

        // LB with two-cycle memory wait
        bus_if.in_valid = 1'b1; bus_if.dm_rd_ctrl_EX = 3'd1; bus_if.alu_result_EX = 64'h1000;
        bus_if.rd_EX = 5'd3; bus_if.rf_wr_en_EX = 1'b1; bus_if.pc_EX = 64'h100;
        bus_if.rf_wr_sel_EX = 2'd1; bus_if.out_ready = 1'b1;
        tick();
        idle_in();
        chk("lb_req", bus_if.dm_req, 1);
        chk("lb_addr", bus_if.dm_addr, 64'h1000);
        chk("lb_rd_ctrl", bus_if.dm_rd_ctrl, 1);
        chk("lb_memorying", bus_if.memorying, 1);
        chk("lb_in_ready", bus_if.in_ready, 0);
        chk("lb_valid_early", bus_if.out_valid, 0);
        tick();
        chk("lb_wait_req", bus_if.dm_req, 1);
        chk("lb_wait_in_ready", bus_if.in_ready, 0);
        bus_if.dm_ack = 1'b1; bus_if.dm_dout = 64'h80;
        #1;
        chk("lb_ack_cycle_valid", bus_if.out_valid, 0);
        tick();
        bus_if.dm_ack = 1'b0;
        chk("lb_valid", bus_if.out_valid, 1);
        chk("lb_data", bus_if.mem_data_MEM, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_req_drop", bus_if.dm_req, 0);
        chk("lb_rd_mem", bus_if.rd_MEM, 3);
        chk("lb_pc", bus_if.pc_WB, 64'h100);
        chk("lb_wr_en", bus_if.rf_wr_en_MEM, 1);
        chk("lb_sel", bus_if.rf_wr_sel_MEM, 1);
        tick();
        chk("lb_drain", bus_if.out_valid, 0);

        // LHU with zero-wait ack
        bus_if.in_valid = 1'b1; bus_if.dm_rd_ctrl_EX = 3'd4; bus_if.alu_result_EX = 64'h1002;
        bus_if.rd_EX = 5'd7;
        tick();
        idle_in();
        chk("lhu_req", bus_if.dm_req, 1);
        bus_if.dm_ack = 1'b1; bus_if.dm_dout = 64'hFFFF_8001;
        tick();
        bus_if.dm_ack = 1'b0;
        chk("lhu_valid", bus_if.out_valid, 1);
        chk("lhu_data", bus_if.mem_data_MEM, 64'h8001);
        tick();
        // stray ack while idle must be ignored
        bus_if.dm_ack = 1'b1; bus_if.dm_dout = 64'h55;
        tick();
        bus_if.dm_ack = 1'b0;
        chk("stray_valid", bus_if.out_valid, 0);
        chk("stray_data", bus_if.mem_data_MEM, 64'h8001);
        chk("stray_req", bus_if.dm_req, 0);

        // SD with WB backpressure
        bus_if.out_ready = 1'b0;
        bus_if.in_valid = 1'b1; bus_if.dm_wr_ctrl_EX = 3'd4; bus_if.alu_result_EX = 64'h2000;
        bus_if.reg_data2_EX = 64'hDEAD_BEEF;
        tick();
        idle_in();
        chk("sd_req", bus_if.dm_req, 1);
        chk("sd_din", bus_if.dm_din, 64'hDEAD_BEEF);
        chk("sd_wr_ctrl", bus_if.dm_wr_ctrl, 4);
        chk("sd_rd_ctrl", bus_if.dm_rd_ctrl, 0);
        bus_if.dm_ack = 1'b1;
        tick();
        bus_if.dm_ack = 1'b0;
        chk("sd_valid", bus_if.out_valid, 1);
        chk("sd_req_drop", bus_if.dm_req, 0);
        chk("sd_data", bus_if.mem_data_MEM, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) bus_if.dm_ack = 1'b1;
            tick();
            bus_if.dm_ack = 1'b0;
            chk("sd_hold_valid", bus_if.out_valid, 1);
            chk("sd_hold_req", bus_if.dm_req, 0);
            chk("sd_hold_din", bus_if.dm_din, 64'hDEAD_BEEF);
            chk("sd_hold_alu", bus_if.alu_result_MEM, 64'h2000);
            chk("sd_hold_in_ready", bus_if.in_ready, 0);
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("sd_release_in_ready", bus_if.in_ready, 1);
        tick();
        chk("sd_release_valid", bus_if.out_valid, 0);
        chk("sd_release_req", bus_if.dm_req, 0);

        // back-to-back ALU ops
        bus_if.in_valid = 1'b1; bus_if.rd_EX = 5'd5; bus_if.alu_result_EX = 64'h55;
        bus_if.rf_wr_sel_EX = 2'd2; bus_if.rf_wr_en_EX = 1'b1;
        tick();
        chk("b2b1_valid", bus_if.out_valid, 1);
        chk("b2b1_rd", bus_if.rd_MEM, 5);
        chk("b2b1_req", bus_if.dm_req, 0);
        chk("b2b1_in_ready", bus_if.in_ready, 1);
        bus_if.rd_EX = 5'd6; bus_if.alu_result_EX = 64'h66;
        tick();
        idle_in();
        chk("b2b2_valid", bus_if.out_valid, 1);
        chk("b2b2_rd", bus_if.rd_MEM, 6);
        chk("b2b2_alu", bus_if.alu_result_MEM, 64'h66);
        chk("b2b2_req", bus_if.dm_req, 0);
        chk("b2b2_data", bus_if.mem_data_MEM, 0);
        tick();
        chk("b2b_drain", bus_if.out_valid, 0);

        // reset during ACCESS, late ack ignored
        bus_if.in_valid = 1'b1; bus_if.dm_rd_ctrl_EX = 3'd5; bus_if.alu_result_EX = 64'h3000;
        tick();
        idle_in();
        chk("rsta_req_pre", bus_if.dm_req, 1);
        reset = 1'b1;
        #1;
        chk("rsta_req_async", bus_if.dm_req, 0);
        chk("rsta_memorying", bus_if.memorying, 0);
        tick();
        reset = 1'b0;
        bus_if.dm_ack = 1'b1; bus_if.dm_dout = 64'hABCD;
        tick();
        bus_if.dm_ack = 1'b0;
        chk("rsta_valid", bus_if.out_valid, 0);
        chk("rsta_req", bus_if.dm_req, 0);
        chk("rsta_data", bus_if.mem_data_MEM, 0);

        // LW with a simultaneous store code: load wins
        bus_if.out_ready = 1'b0;
        bus_if.in_valid = 1'b1; bus_if.dm_rd_ctrl_EX = 3'd5; bus_if.dm_wr_ctrl_EX = 3'd3;
        bus_if.alu_result_EX = 64'h3004; bus_if.reg_data2_EX = 64'h99;
        tick();
        idle_in();
        chk("lw_rd_ctrl", bus_if.dm_rd_ctrl, 5);
        chk("lw_wr_ctrl", bus_if.dm_wr_ctrl, 0);
        chk("lw_req", bus_if.dm_req, 1);
        bus_if.dm_ack = 1'b1; bus_if.dm_dout = 64'h1234_5678_8000_0001;
        tick();
        bus_if.dm_ack = 1'b0;
        chk("lw_valid", bus_if.out_valid, 1);
        chk("lw_data", bus_if.mem_data_MEM, 64'hFFFF_FFFF_8000_0001);

        // LWU accepted straight out of HOLD
        bus_if.in_valid = 1'b1; bus_if.dm_rd_ctrl_EX = 3'd6; bus_if.alu_result_EX = 64'h3008;
        #1;
        chk("lwu_blocked", bus_if.in_ready, 0);
        bus_if.out_ready = 1'b1;
        #1;
        chk("lwu_ready", bus_if.in_ready, 1);
        tick();
        idle_in();
        chk("lwu_valid_drop", bus_if.out_valid, 0);
        chk("lwu_req", bus_if.dm_req, 1);
        chk("lwu_addr", bus_if.dm_addr, 64'h3008);
        bus_if.dm_ack = 1'b1;
        tick();
        bus_if.dm_ack = 1'b0;
        chk("lwu_data", bus_if.mem_data_MEM, 64'h8000_0001);

        // LD
        bus_if.in_valid = 1'b1; bus_if.dm_rd_ctrl_EX = 3'd7; bus_if.alu_result_EX = 64'h3010;
        tick();
        idle_in();
        bus_if.dm_ack = 1'b1; bus_if.dm_dout = 64'h8123_4567_89AB_CDEF;
        tick();
        bus_if.dm_ack = 1'b0;
        chk("ld_data", bus_if.mem_data_MEM, 64'h8123_4567_89AB_CDEF);
        tick();

`ifdef MEM_MISALIGN_CHECK_EN
        bus_if.in_valid = 1'b1; bus_if.dm_rd_ctrl_EX = 3'd5; bus_if.alu_result_EX = 64'h1002;
        bus_if.rf_wr_en_EX = 1'b1;
        tick();
        idle_in();
        chk("mis_req", bus_if.dm_req, 0);
        chk("mis_flag", bus_if.misalign_MEM, 1);
        chk("mis_wr_en", bus_if.rf_wr_en_MEM, 0);
        chk("mis_valid", bus_if.out_valid, 1);
        chk("mis_data", bus_if.mem_data_MEM, 0);
        bus_if.in_valid = 1'b1; bus_if.alu_result_EX = 64'h40;
        tick();
        idle_in();
        chk("mis_clear", bus_if.misalign_MEM, 0);
        tick();
`else
        bus_if.in_valid = 1'b1; bus_if.dm_rd_ctrl_EX = 3'd5; bus_if.alu_result_EX = 64'h1002;
        tick();
        idle_in();
        chk("unal_req", bus_if.dm_req, 1);
        chk("unal_addr", bus_if.dm_addr, 64'h1002);
        bus_if.dm_ack = 1'b1;
        tick();
        bus_if.dm_ack = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
